// File: rtl/pll_lock_rst_seq.sv
// PLL lock supervisor and staged reset sequencer.
// Pulses the PLL reset and waits for a stable lock. It then releases the core,
// peripheral and IO resets in that order, with a fixed spacing between them.
// A lock drop after release reasserts all three resets together. A drop in the
// release phases does not re-pulse the PLL; a lock timeout does.
module pll_lock_rst_seq #(
  parameter int unsigned SYNC_STAGES         = 2,
  parameter int unsigned PLL_RST_CYCLES      = 8,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned STAGGER_CYCLES      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       rst_core,
  output logic       rst_periph,
  output logic       rst_io,
  output logic       ready,
  output logic [7:0] lock_loss_cnt,
  output logic       timeout_err
);

  localparam int unsigned MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                    PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned MAX_CD  = (LOCK_STABLE_CYCLES > 2 * STAGGER_CYCLES) ?
                                    LOCK_STABLE_CYCLES : 2 * STAGGER_CYCLES;
  localparam int unsigned MAX_ALL = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CNT_W   = $clog2(MAX_ALL + 1);

  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PERIPH_AT    = CNT_W'(STAGGER_CYCLES);
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(2 * STAGGER_CYCLES - 1);

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_STABLE,
    S_RELEASE,
    S_RUN
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_locked_s;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   w_timeout;
  logic                   w_drop;

  logic                   w_pll_rst;
  logic                   w_rst_core;
  logic                   w_rst_periph;
  logic                   w_rst_io;
  logic                   w_ready;

  logic                   r_pll_rst;
  logic                   r_rst_core;
  logic                   r_rst_periph;
  logic                   r_rst_io;
  logic                   r_ready;
  logic [7:0]             r_lock_loss_cnt;
  logic                   r_timeout_err;

  assign w_locked_s = r_sync[SYNC_STAGES-1];

  // Bring the asynchronous lock indicator into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pll_locked};
    end
  end

  // State register and the shared state counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_PLL_RST;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state decode; the counter clears on every state change and idles in RUN.
  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    w_drop      = 1'b0;
    unique case (r_state)
      S_PLL_RST: begin
        if (r_cnt == PLL_RST_LAST) w_state_nxt = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (w_locked_s) begin
          w_state_nxt = S_STABLE;
        end else if (r_cnt == TIMEOUT_LAST) begin
          w_state_nxt = S_PLL_RST;
          w_timeout   = 1'b1;
        end
      end
      S_STABLE: begin
        if (!w_locked_s)                w_state_nxt = S_WAIT_LOCK;
        else if (r_cnt == STABLE_LAST)  w_state_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        if (!w_locked_s) begin
          w_state_nxt = S_WAIT_LOCK;
          w_drop      = 1'b1;
        end else if (r_cnt == RELEASE_LAST) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (!w_locked_s) begin
          w_state_nxt = S_WAIT_LOCK;
          w_drop      = 1'b1;
        end
      end
      default: w_state_nxt = S_PLL_RST;
    endcase

    if (w_state_nxt != r_state) w_cnt_nxt = '0;
    else if (r_state == S_RUN)  w_cnt_nxt = r_cnt;
    else                        w_cnt_nxt = r_cnt + CNT_W'(1);
  end

  // Output decode from the next state. The outputs are registered alongside the
  // state, so they stay glitch-free and change on the same edge as the state.
  always_comb begin
    w_pll_rst    = (w_state_nxt == S_PLL_RST);
    w_rst_core   = !((w_state_nxt == S_RELEASE) || (w_state_nxt == S_RUN));
    w_rst_periph = !((w_state_nxt == S_RUN) ||
                     ((w_state_nxt == S_RELEASE) && (w_cnt_nxt >= PERIPH_AT)));
    w_rst_io     = (w_state_nxt != S_RUN);
    w_ready      = (w_state_nxt == S_RUN);
  end

  // Registered reset outputs and ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pll_rst    <= 1'b1;
      r_rst_core   <= 1'b1;
      r_rst_periph <= 1'b1;
      r_rst_io     <= 1'b1;
      r_ready      <= 1'b0;
    end else begin
      r_pll_rst    <= w_pll_rst;
      r_rst_core   <= w_rst_core;
      r_rst_periph <= w_rst_periph;
      r_rst_io     <= w_rst_io;
      r_ready      <= w_ready;
    end
  end

  // Status: saturating lock-loss counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock_loss_cnt <= '0;
      r_timeout_err   <= 1'b0;
    end else begin
      if (w_drop && (r_lock_loss_cnt != '1)) r_lock_loss_cnt <= r_lock_loss_cnt + 8'd1;
      if (w_timeout) r_timeout_err <= 1'b1;
    end
  end

  assign pll_rst       = r_pll_rst;
  assign rst_core      = r_rst_core;
  assign rst_periph    = r_rst_periph;
  assign rst_io        = r_rst_io;
  assign ready         = r_ready;
  assign lock_loss_cnt = r_lock_loss_cnt;
  assign timeout_err   = r_timeout_err;

endmodule

// File: tb/tb_pll_lock_rst_seq.sv
// Scoreboard bench for pll_lock_rst_seq. The stimulus pushes every expected
// output change, with the cycle on which it must occur, into a queue. A monitor
// pops one entry on each observed change and compares cycle and value.
module tb_pll_lock_rst_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       pll_rst;
  logic       rst_core;
  logic       rst_periph;
  logic       rst_io;
  logic       ready;
  logic [7:0] lock_loss_cnt;
  logic       timeout_err;

  pll_lock_rst_seq #(
    .SYNC_STAGES        (2),
    .PLL_RST_CYCLES     (4),
    .LOCK_TIMEOUT_CYCLES(32),
    .LOCK_STABLE_CYCLES (8),
    .STAGGER_CYCLES     (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .pll_rst      (pll_rst),
    .rst_core     (rst_core),
    .rst_periph   (rst_periph),
    .rst_io       (rst_io),
    .ready        (ready),
    .lock_loss_cnt(lock_loss_cnt),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [13:0] vec;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   tests  = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [13:0] mk(input logic pr, input logic c, input logic p,
                                     input logic i, input logic rdy, input logic te,
                                     input logic [7:0] l);
    return {pr, c, p, i, rdy, te, l};
  endfunction

  task automatic push(input int c, input logic [13:0] v);
    exp_t e;
    e.cyc = c;
    e.vec = v;
    q.push_back(e);
  endtask

  // Release sequence expected once STABLE is entered on cycle s.
  task automatic exp_release(input int s, input logic te, input logic [7:0] l);
    push(s + 8,  mk(0, 0, 1, 1, 0, te, l));
    push(s + 12, mk(0, 0, 0, 1, 0, te, l));
    push(s + 16, mk(0, 0, 0, 0, 1, te, l));
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every change of the output bundle consumes one expected entry.
  logic [13:0] prev = 'x;
  always @(negedge clk) begin
    logic [13:0] cur;
    exp_t        e;
    cur = {pll_rst, rst_core, rst_periph, rst_io, ready, timeout_err, lock_loss_cnt};
    if (cur !== prev) begin
      tests = tests + 1;
      if (q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_change: cyc=%0d vec=%b, required no change", cyc, cur);
      end else begin
        e = q.pop_front();
        if ((e.cyc != cyc) || (e.vec !== cur)) begin
          errors = errors + 1;
          $display("FAIL out_change: got cyc=%0d vec=%b, required cyc=%0d vec=%b",
                   cyc, cur, e.cyc, e.vec);
        end
      end
      prev = cur;
    end
  end

  localparam logic [13:0] R0 = 14'b11110_0_00000000;
  localparam logic [13:0] W0 = 14'b01110_0_00000000;

  initial begin
    int          d;
    int          r;
    logic [7:0]  l;

    // Nominal start: lock present throughout, reset held for two edges.
    rst        = 1'b1;
    pll_locked = 1'b1;
    push(1, R0);
    wait_until(2);
    rst = 1'b0;
    push(6, W0);
    exp_release(7, 1'b0, 8'd0);

    // Three-cycle lock loss in RUN, then a drop landing on the rst_io release.
    wait_until(30);
    d = cyc;
    pll_locked = 1'b0;
    push(d + 3, mk(0, 1, 1, 1, 0, 0, 8'd1));
    wait_until(d + 3);
    pll_locked = 1'b1;
    push(d + 14, mk(0, 0, 1, 1, 0, 0, 8'd1));
    push(d + 18, mk(0, 0, 0, 1, 0, 0, 8'd1));
    wait_until(d + 19);
    pll_locked = 1'b0;
    wait_until(d + 20);
    pll_locked = 1'b1;
    push(d + 22, mk(0, 1, 1, 1, 0, 0, 8'd2));
    exp_release(d + 23, 1'b0, 8'd2);

    // Unstable lock: 5 high, 1 low, then high.
    wait_until(75);
    rst        = 1'b1;
    pll_locked = 1'b0;
    push(76, R0);
    wait_until(76);
    rst = 1'b0;
    push(80, W0);
    wait_until(80);
    pll_locked = 1'b1;
    wait_until(85);
    pll_locked = 1'b0;
    wait_until(86);
    pll_locked = 1'b1;
    exp_release(89, 1'b0, 8'd0);

    // No lock: timeout, second PLL pulse, then lock returns with the flag sticky.
    wait_until(110);
    rst        = 1'b1;
    pll_locked = 1'b0;
    push(111, R0);
    wait_until(111);
    rst = 1'b0;
    push(115, W0);
    push(147, mk(1, 1, 1, 1, 0, 1, 8'd0));
    push(151, mk(0, 1, 1, 1, 0, 1, 8'd0));
    wait_until(151);
    pll_locked = 1'b1;
    exp_release(154, 1'b1, 8'd0);

    // Sub-cycle glitch between edges must leave RUN untouched.
    wait_until(172);
    pll_locked = 1'b0;
    #3;
    pll_locked = 1'b1;

    // 260 single-cycle lock losses in RUN; counter saturates at 255.
    wait_until(175);
    l = 8'd0;
    for (int i = 0; i < 260; i++) begin
      d = cyc;
      l = (l == 8'd255) ? 8'd255 : l + 8'd1;
      pll_locked = 1'b0;
      push(d + 3, mk(0, 1, 1, 1, 0, 1, l));
      wait_until(d + 1);
      pll_locked = 1'b1;
      exp_release(d + 4, 1'b1, l);
      wait_until(d + 21);
    end

    // One more loss, then rst between the rst_periph and rst_io releases.
    d = cyc;
    pll_locked = 1'b0;
    push(d + 3, mk(0, 1, 1, 1, 0, 1, 8'd255));
    wait_until(d + 1);
    pll_locked = 1'b1;
    push(d + 12, mk(0, 0, 1, 1, 0, 1, 8'd255));
    push(d + 16, mk(0, 0, 0, 1, 0, 1, 8'd255));
    wait_until(d + 17);
    rst = 1'b1;
    push(d + 18, R0);
    wait_until(d + 18);
    rst = 1'b0;
    r = d + 18;
    push(r + 4, W0);
    exp_release(r + 5, 1'b0, 8'd0);

    wait_until(r + 30);
    @(negedge clk);
    #1;
    tests = tests + 1;
    if (q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL missing_changes: %0d expected changes never seen, required 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
